// File: rtl/bram_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bram_arbiter_if
// Brief    : One requester's request/response channel into bram_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface bram_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/bram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bram_arbiter
// Brief    : Round-robin sharing of one bram between two requesters, plus a
//            whole-memory fill engine.
// Revision : 1.0 - initial release
// ============================================================================
module bram_arbiter #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fill_start,
    input  logic [DW-1:0] fill_value,
    output logic          fill_busy,
    bram_arbiter_if.slave a,
    bram_arbiter_if.slave b,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_wr_data
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    localparam logic [AW-1:0] C_LAST_ADDR = '1;
    localparam logic [AW-1:0] C_ONE       = AW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_ptr_b;        // 1: B wins the next contended cycle
    logic [AW-1:0] r_fill_cnt;
    logic [DW-1:0] r_fill_val;
    logic          r_rsp_pend;
    logic          r_rsp_to_b;

    logic          w_grant_a;
    logic          w_grant_b;
    logic          w_grant_any;
    logic          w_fill_accept;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    // Payload of whichever requester would win; only used when a grant exists.
    assign w_sel_we    = w_grant_b ? b.req_we    : a.req_we;
    assign w_sel_addr  = w_grant_b ? b.req_addr  : a.req_addr;
    assign w_sel_wdata = w_grant_b ? b.req_wdata : a.req_wdata;
    assign w_grant_any = w_grant_a | w_grant_b;

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_a     = 1'b0;
        w_grant_b     = 1'b0;
        w_fill_accept = 1'b0;
        mem_rd_en     = 1'b0;
        mem_rd_addr   = '0;
        mem_wr_en     = 1'b0;
        mem_wr_addr   = '0;
        mem_wr_data   = '0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (fill_start) begin
                        w_fill_accept = 1'b1;
                        w_state_nxt   = S_FILL;
                    end else begin
                        w_grant_a = a.req_valid && (!b.req_valid || !r_ptr_b);
                        w_grant_b = b.req_valid && (!a.req_valid ||  r_ptr_b);
                    end
                    if (w_grant_a || w_grant_b) begin
                        mem_rd_en   = !w_sel_we;
                        mem_rd_addr = w_sel_addr;
                        mem_wr_en   = w_sel_we;
                        mem_wr_addr = w_sel_addr;
                        mem_wr_data = w_sel_wdata;
                    end
                end
                S_FILL: begin
                    mem_wr_en   = 1'b1;
                    mem_wr_addr = r_fill_cnt;
                    mem_wr_data = r_fill_val;
                    if (r_fill_cnt == C_LAST_ADDR) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr_b    <= 1'b0;
            r_fill_cnt <= '0;
            r_fill_val <= '0;
            r_rsp_pend <= 1'b0;
            r_rsp_to_b <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fill_accept) begin
                r_fill_val <= fill_value;
                r_fill_cnt <= '0;
            end else if (r_state == S_FILL) begin
                r_fill_cnt <= r_fill_cnt + C_ONE;
            end
            if (w_grant_any) begin
                r_ptr_b <= w_grant_a;
            end
            r_rsp_pend <= w_grant_any && !w_sel_we;
            r_rsp_to_b <= w_grant_b;
        end
    end

    assign fill_busy   = (r_state == S_FILL) && !rst;
    assign a.req_ready = w_grant_a;
    assign b.req_ready = w_grant_b;
    assign a.rsp_valid = r_rsp_pend && !r_rsp_to_b && !rst;
    assign b.rsp_valid = r_rsp_pend &&  r_rsp_to_b && !rst;
    assign a.rsp_data  = mem_rd_data;
    assign b.rsp_data  = mem_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_bram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bram_arbiter
// Brief    : Self-checking bench for bram_arbiter with a bram model and a
//            behavioural reference of arbitration, memory and fill.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_arbiter;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          fill_start;
    logic [DW-1:0] fill_value;
    logic          fill_busy;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [AW-1:0] mem_rd_addr;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] mem_wr_data;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] bram    [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    bit            preloaded = 1'b0;

    bram_arbiter_if #(.AW(AW), .DW(DW)) a_if ();
    bram_arbiter_if #(.AW(AW), .DW(DW)) b_if ();

    bram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .fill_start  (fill_start),
        .fill_value  (fill_value),
        .fill_busy   (fill_busy),
        .a           (a_if),
        .b           (b_if),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data)
    );

    always #5 clk = ~clk;

    // Bram with registered read; preloaded with a known pattern on the first edge.
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < DEPTH; i++) bram[i] <= DW'(i * 37 + 11);
            preloaded <= 1'b1;
        end else begin
            if (mem_wr_en) bram[mem_wr_addr] <= mem_wr_data;
            if (mem_rd_en) mem_rd_data <= bram[mem_rd_addr];
        end
    end

    always @(negedge clk) begin
        checks++;
        assert (!(mem_rd_en && mem_wr_en)) else begin
            errors++;
            $display("FAIL port_exclusive: rd_en=%0b wr_en=%0b required not both 1 at %0t",
                     mem_rd_en, mem_wr_en, $time);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fill_start       = 1'b0;
        fill_value       = '0;
        a_if.req_valid   = 1'b0;
        a_if.req_we      = 1'b0;
        a_if.req_addr    = '0;
        a_if.req_wdata   = '0;
        b_if.req_valid   = 1'b0;
        b_if.req_we      = 1'b0;
        b_if.req_addr    = '0;
        b_if.req_wdata   = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_a(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        a_if.req_valid = 1'b1;
        a_if.req_we    = we;
        a_if.req_addr  = addr;
        a_if.req_wdata = wd;
    endtask

    task automatic set_b(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        b_if.req_valid = 1'b1;
        b_if.req_we    = we;
        b_if.req_addr  = addr;
        b_if.req_wdata = wd;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        set_a(1'b0, AW'(2), '0);
        set_b(1'b0, AW'(4), '0);
        fill_start = 1'b1;
        @(negedge clk);
        checks++; if (a_if.req_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready: got %b want 0", a_if.req_ready); end
        checks++; if (b_if.req_ready !== 1'b0) begin errors++; $display("FAIL rst_b_ready: got %b want 0", b_if.req_ready); end
        checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL rst_fill_busy: got %b want 0", fill_busy); end
        checks++; if ({mem_rd_en, mem_wr_en} !== 2'b00) begin errors++; $display("FAIL rst_mem_en: got %b want 00", {mem_rd_en, mem_wr_en}); end
        checks++; if ({a_if.rsp_valid, b_if.rsp_valid} !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b want 00", {a_if.rsp_valid, b_if.rsp_valid}); end
        tick();
        tick();
        rst = 1'b0;
        fill_start = 1'b0;
        b_if.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (a_if.req_ready !== 1'b1) begin errors++; $display("FAIL rst_drop_accept: a_ready got %b want 1", a_if.req_ready); end
        tick();
        rst = 1'b1;
        a_if.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (a_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_drop_rsp: a_rsp_valid got %b want 0", a_if.rsp_valid); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_drop_rsp_after: a_rsp_valid got %b want 0", a_if.rsp_valid); end
    endtask

    task automatic test_write_read();
        apply_reset();
        set_a(1'b1, AW'(3), 8'h5A);
        @(negedge clk);
        checks++; if (a_if.req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", a_if.req_ready); end
        checks++; if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, AW'(3), 8'h5A})
            begin errors++; $display("FAIL wr_port: got en=%b addr=%0d data=%h want 1/3/5a", mem_wr_en, mem_wr_addr, mem_wr_data); end
        ref_mem[3] = 8'h5A;
        tick();
        set_a(1'b0, AW'(3), '0);
        @(negedge clk);
        checks++; if ({a_if.req_ready, mem_rd_en} !== 2'b11) begin errors++; $display("FAIL rd_accept: ready/rd_en got %b want 11", {a_if.req_ready, mem_rd_en}); end
        tick();
        a_if.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (a_if.rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp_valid: got %b want 1", a_if.rsp_valid); end
        checks++; if (a_if.rsp_data !== 8'h5A) begin errors++; $display("FAIL rd_rsp_data: got %h want 5a", a_if.rsp_data); end
        checks++; if (b_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_b_rsp: got %b want 0", b_if.rsp_valid); end
        tick();
        @(negedge clk);
        checks++; if (a_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_pulse: got %b want 0", a_if.rsp_valid); end
    endtask

    task automatic test_alternating();
        int            a_addr = 10;
        int            b_addr = 20;
        bit            exp_a;
        bit            prev_a = 1'b0;
        logic [DW-1:0] prev_data = '0;
        apply_reset();
        set_a(1'b0, AW'(a_addr), '0);
        set_b(1'b0, AW'(b_addr), '0);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            exp_a = (k % 2 == 0);
            if (k < 4) begin
                checks++; if ({a_if.req_ready, b_if.req_ready} !== {exp_a, !exp_a})
                    begin errors++; $display("FAIL alt_grant[%0d]: got a=%b b=%b want a=%b", k, a_if.req_ready, b_if.req_ready, exp_a); end
            end
            if (k > 0) begin
                checks++; if ({a_if.rsp_valid, b_if.rsp_valid} !== {prev_a, !prev_a})
                    begin errors++; $display("FAIL alt_rsp_owner[%0d]: got a=%b b=%b want a=%b", k, a_if.rsp_valid, b_if.rsp_valid, prev_a); end
                checks++; if (a_if.rsp_data !== prev_data)
                    begin errors++; $display("FAIL alt_rsp_data[%0d]: got %h want %h", k, a_if.rsp_data, prev_data); end
            end
            if (k < 4) begin
                prev_a    = exp_a;
                prev_data = exp_a ? ref_mem[a_addr] : ref_mem[b_addr];
            end
            tick();
            if (k < 4) begin
                if (exp_a) begin a_addr++; a_if.req_addr = AW'(a_addr); end
                else begin b_addr++; b_if.req_addr = AW'(b_addr); end
            end
            if (k == 3) clear_inputs();
        end
    endtask

    task automatic test_raw();
        logic [DW-1:0] v;
        apply_reset();
        v = DW'($urandom_range(255));
        set_a(1'b1, AW'(7), v);
        set_b(1'b0, AW'(7), '0);
        @(negedge clk);
        checks++; if ({a_if.req_ready, b_if.req_ready, mem_wr_en} !== 3'b101)
            begin errors++; $display("FAIL raw_first: a/b/wr got %b want 101", {a_if.req_ready, b_if.req_ready, mem_wr_en}); end
        ref_mem[7] = v;
        tick();
        a_if.req_valid = 1'b0;
        @(negedge clk);
        checks++; if ({b_if.req_ready, mem_rd_en, mem_wr_en} !== 3'b110)
            begin errors++; $display("FAIL raw_second: b/rd/wr got %b want 110", {b_if.req_ready, mem_rd_en, mem_wr_en}); end
        tick();
        b_if.req_valid = 1'b0;
        @(negedge clk);
        checks++; if ({a_if.rsp_valid, b_if.rsp_valid} !== 2'b01) begin errors++; $display("FAIL raw_owner: a/b got %b want 01", {a_if.rsp_valid, b_if.rsp_valid}); end
        checks++; if (b_if.rsp_data !== v) begin errors++; $display("FAIL raw_data: got %h want %h", b_if.rsp_data, v); end
    endtask

    task automatic test_read_then_fill();
        logic [AW-1:0] r;
        apply_reset();
        r = AW'($urandom_range(DEPTH - 1));
        set_a(1'b0, r, '0);
        @(negedge clk);
        checks++; if (a_if.req_ready !== 1'b1) begin errors++; $display("FAIL rtf_accept: got %b want 1", a_if.req_ready); end
        tick();
        a_if.req_valid = 1'b0;
        fill_start     = 1'b1;
        fill_value     = 8'h5C;
        @(negedge clk);
        checks++; if ({a_if.rsp_valid, b_if.rsp_valid, fill_busy} !== 3'b100)
            begin errors++; $display("FAIL rtf_rsp: a/b/busy got %b want 100", {a_if.rsp_valid, b_if.rsp_valid, fill_busy}); end
        checks++; if (a_if.rsp_data !== ref_mem[r]) begin errors++; $display("FAIL rtf_data: got %h want %h", a_if.rsp_data, ref_mem[r]); end
        tick();
        fill_start = 1'b0;
        @(negedge clk);
        checks++; if ({a_if.rsp_valid, fill_busy} !== 2'b01) begin errors++; $display("FAIL rtf_in_fill: rsp/busy got %b want 01", {a_if.rsp_valid, fill_busy}); end
        repeat (DEPTH - 1) tick();
        @(negedge clk);
        checks++; if ({fill_busy, mem_wr_addr} !== {1'b1, AW'(DEPTH - 1)})
            begin errors++; $display("FAIL rtf_last: busy=%b addr=%0d want 1/%0d", fill_busy, mem_wr_addr, DEPTH - 1); end
        tick();
        @(negedge clk);
        checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL rtf_done: busy got %b want 0", fill_busy); end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h5C;
    endtask

    task automatic test_fill();
        int            bad = 0;
        int            addrs [3] = '{0, 511, 1023};
        apply_reset();
        set_b(1'b0, AW'(5), '0);
        fill_start = 1'b1;
        fill_value = 8'hFF;
        @(negedge clk);
        checks++; if ({b_if.req_ready, fill_busy, mem_rd_en} !== 3'b000)
            begin errors++; $display("FAIL fill_start_cycle: ready/busy/rd got %b want 000", {b_if.req_ready, fill_busy, mem_rd_en}); end
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 500) begin fill_start = 1'b1; fill_value = 8'h11; end
            if (i == 501) fill_start = 1'b0;
            @(negedge clk);
            if (fill_busy !== 1'b1 || b_if.req_ready !== 1'b0 || mem_wr_en !== 1'b1 ||
                mem_wr_addr !== AW'(i) || mem_wr_data !== 8'hFF) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL fill_sequence: %0d bad cycles want 0", bad); end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hFF;
        @(negedge clk);
        checks++; if ({fill_busy, b_if.req_ready} !== 2'b01) begin errors++; $display("FAIL fill_end: busy/b_ready got %b want 01", {fill_busy, b_if.req_ready}); end
        tick();
        b_if.req_valid = 1'b0;
        for (int j = 0; j <= 3; j++) begin
            if (j < 3) set_a(1'b0, AW'(addrs[j]), '0);
            else a_if.req_valid = 1'b0;
            @(negedge clk);
            if (j == 0) begin
                checks++; if ({b_if.rsp_valid, b_if.rsp_data} !== {1'b1, 8'hFF})
                    begin errors++; $display("FAIL fill_b_rsp: got v=%b d=%h want 1/ff", b_if.rsp_valid, b_if.rsp_data); end
            end else begin
                checks++; if ({a_if.rsp_valid, a_if.rsp_data} !== {1'b1, ref_mem[addrs[j-1]]})
                    begin errors++; $display("FAIL fill_readback[%0d]: got v=%b d=%h want 1/ff", addrs[j-1], a_if.rsp_valid, a_if.rsp_data); end
            end
            if (j < 3) begin
                checks++; if (a_if.req_ready !== 1'b1) begin errors++; $display("FAIL fill_rd_ready[%0d]: got %b want 1", j, a_if.req_ready); end
            end
            tick();
        end
    endtask

    task automatic test_rst_mid_fill();
        int bad = 0;
        apply_reset();
        fill_start = 1'b1;
        fill_value = 8'h33;
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fill_busy !== 1'b1 || mem_wr_addr !== AW'(i)) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rmf_prefix: %0d bad cycles want 0", bad); end
        rst = 1'b1;
        set_a(1'b1, AW'(900), 8'h44);
        @(negedge clk);
        checks++; if ({fill_busy, a_if.req_ready, mem_wr_en} !== 3'b000)
            begin errors++; $display("FAIL rmf_in_rst: busy/ready/wr got %b want 000", {fill_busy, a_if.req_ready, mem_wr_en}); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({fill_busy, a_if.req_ready, b_if.req_ready} !== 3'b010)
            begin errors++; $display("FAIL rmf_after: busy/a/b got %b want 010", {fill_busy, a_if.req_ready, b_if.req_ready}); end
        checks++; if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, AW'(900), 8'h44})
            begin errors++; $display("FAIL rmf_write: en=%b addr=%0d data=%h want 1/900/44", mem_wr_en, mem_wr_addr, mem_wr_data); end
        tick();
        a_if.req_valid = 1'b0;
        fill_start     = 1'b1;
        fill_value     = 8'hC3;
        tick();
        fill_start = 1'b0;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (fill_busy !== 1'b1 || mem_wr_en !== 1'b1 || mem_wr_addr !== AW'(i) || mem_wr_data !== 8'hC3) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rmf_full_fill: %0d bad cycles want 0", bad); end
        @(negedge clk);
        checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL rmf_done: busy got %b want 0", fill_busy); end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hC3;
    endtask

    task automatic test_random();
        bit            last_b = 1'b1;   // reset priority: A goes first
        bit            ga;
        bit            gb;
        bit            exp_rsp_a = 1'b0;
        bit            exp_rsp_b = 1'b0;
        logic [DW-1:0] exp_data = '0;
        logic [DW-1:0] got_data;
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!a_if.req_valid && $urandom_range(3) != 0)
                set_a(1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom));
            if (!b_if.req_valid && $urandom_range(3) != 0)
                set_b(1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom));
            @(negedge clk);
            ga = a_if.req_valid && (!b_if.req_valid || last_b);
            gb = b_if.req_valid && !ga;
            checks++; if (a_if.req_ready !== ga) begin errors++; $display("FAIL rnd_a_ready[%0d]: got %b want %b", cyc, a_if.req_ready, ga); end
            checks++; if (b_if.req_ready !== gb) begin errors++; $display("FAIL rnd_b_ready[%0d]: got %b want %b", cyc, b_if.req_ready, gb); end
            checks++; if ({a_if.rsp_valid, b_if.rsp_valid} !== {exp_rsp_a, exp_rsp_b})
                begin errors++; $display("FAIL rnd_rsp_valid[%0d]: got %b%b want %b%b", cyc, a_if.rsp_valid, b_if.rsp_valid, exp_rsp_a, exp_rsp_b); end
            if (exp_rsp_a || exp_rsp_b) begin
                got_data = exp_rsp_a ? a_if.rsp_data : b_if.rsp_data;
                checks++; if (got_data !== exp_data) begin errors++; $display("FAIL rnd_rsp_data[%0d]: got %h want %h", cyc, got_data, exp_data); end
            end
            exp_rsp_a = 1'b0;
            exp_rsp_b = 1'b0;
            if (ga) begin
                if (a_if.req_we) ref_mem[a_if.req_addr] = a_if.req_wdata;
                else begin exp_rsp_a = 1'b1; exp_data = ref_mem[a_if.req_addr]; end
                last_b = 1'b0;
            end
            if (gb) begin
                if (b_if.req_we) ref_mem[b_if.req_addr] = b_if.req_wdata;
                else begin exp_rsp_b = 1'b1; exp_data = ref_mem[b_if.req_addr]; end
                last_b = 1'b1;
            end
            tick();
            if (ga) a_if.req_valid = 1'b0;
            if (gb) b_if.req_valid = 1'b0;
        end
        clear_inputs();
        @(negedge clk);
        checks++; if ({a_if.rsp_valid, b_if.rsp_valid} !== {exp_rsp_a, exp_rsp_b})
            begin errors++; $display("FAIL rnd_tail_valid: got %b%b want %b%b", a_if.rsp_valid, b_if.rsp_valid, exp_rsp_a, exp_rsp_b); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(i * 37 + 11);
        test_reset();
        test_write_read();
        test_alternating();
        test_raw();
        test_read_then_fill();
        test_fill();
        test_rst_mid_fill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
